// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding,
// index-width calculation and packed-bus slicing.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Requester index width; never below one bit so a vector is always declarable.
  function automatic int calc_iw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Low bit of word idx inside a packed bus of dw-bit words.
  function automatic int slice_lo(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req scanning from ptr
// upward, wrapping modulo N.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down so the closest-to-ptr request wins.
  always_comb begin
    any    = |req;
    idx    = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IW'((int'(ptr) + k) % N);
      if (req[w_cand]) idx = w_cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// with bounded bursts, idle timeout and full / prog_full backpressure.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DW        = 16,
  parameter  int MAX_BURST = 8,
  parameter  int TIMEOUT   = 15,
  localparam int IW        = calc_iw(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]  req_last,
  output logic [NREQ-1:0]  req_ready,
  output logic             fifo_wren,
  output logic [DW-1:0]    fifo_wdata,
  input  logic             fifo_wfull,
  input  logic             fifo_prog_full,
  output logic             grant_vld,
  output logic [IW-1:0]    grant_id
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [IW-1:0]   r_gnt_q;
  logic [IW-1:0]   r_rr_ptr;
  logic [BW-1:0]   r_beat_cnt;
  logic [TW-1:0]   r_idle_cnt;

  logic            w_pick_any;
  logic [IW-1:0]   w_pick_idx;
  logic [IW-1:0]   w_gnt_next;
  logic            w_busy;
  logic            w_ready_g;
  logic            w_xfer;
  logic            w_last_beat;
  logic            w_idle_cyc;
  logic            w_timeout;
  logic [DW-1:0]   w_req_words [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_req_words[gi] = req_data[slice_lo(gi, DW) +: DW];
  end

  fifo_wr_arbiter_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  // Holding rst masks the outputs so no beat is accepted on the reset edge.
  assign w_busy      = (r_state == ST_BUSY) && !rst;
  assign w_ready_g   = w_busy && !fifo_wfull;
  assign w_xfer      = w_ready_g && req_valid[r_gnt_q];
  assign w_last_beat = req_last[r_gnt_q] || (r_beat_cnt == BW'(MAX_BURST - 1));
  assign w_idle_cyc  = w_ready_g && !req_valid[r_gnt_q];
  assign w_timeout   = w_idle_cyc && (r_idle_cnt == TW'(TIMEOUT - 1));
  assign w_gnt_next  = (r_gnt_q == IW'(NREQ - 1)) ? '0 : r_gnt_q + IW'(1);

  always_comb begin
    req_ready = '0;
    if (w_ready_g) req_ready[r_gnt_q] = 1'b1;
  end

  assign fifo_wren  = w_xfer;
  assign fifo_wdata = w_busy ? w_req_words[r_gnt_q] : '0;
  assign grant_vld  = w_busy;
  assign grant_id   = w_busy ? r_gnt_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_q    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any && !fifo_prog_full) begin
            r_gnt_q    <= w_pick_idx;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            r_idle_cnt <= '0;
            if (w_last_beat) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_gnt_next;
            end
          end else if (w_idle_cyc) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
            if (w_timeout) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_gnt_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one FIFO write port among NREQ requesters. Lives in the FIFO write-clock domain. Grants one requester at a time for a burst of up to MAX_BURST beats, or until that requester asserts last. Applies backpressure from the FIFO full flags: prog_full blocks new bursts, full stalls the current burst.

Parameters:
NREQ, 4, number of requesters (>= 2)
DW, 16, data width; matches the FIFO DW
MAX_BURST, 8, max beats per grant (>= 1)
TIMEOUT, 15, consecutive idle cycles inside a burst before the grant is revoked (>= 1)
IW, $clog2(NREQ), localparam, requester index width

Ports:
clk  in  1  clock (FIFO write clock)
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*DW  packed data; requester i at [i*DW +: DW]
req_last  in  NREQ  last beat of the requester's burst
req_ready  out  NREQ  per-requester accept
fifo_wren  out  1  FIFO write enable
fifo_wdata  out  DW  FIFO write data
fifo_wfull  in  1  FIFO full flag
fifo_prog_full  in  1  FIFO programmable-full flag
grant_vld  out  1  a burst is in progress
grant_id  out  IW  index of the granted requester

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- State and counters:
  - FSM states are IDLE and BUSY.
  - Registers: gnt_q (IW bits), rr_ptr (IW bits), beat_cnt (covers 0..MAX_BURST), idle_cnt (covers 0..TIMEOUT).
- Reset values:
  - state=IDLE; gnt_q, rr_ptr, beat_cnt, idle_cnt = 0.
  - All outputs 0: req_ready, fifo_wren, fifo_wdata, grant_vld, grant_id.
- IDLE:
  - req_ready=0, fifo_wren=0.
  - If |req_valid and !fifo_prog_full: pick the first valid index scanning rr_ptr, rr_ptr+1, … modulo NREQ. Load gnt_q, clear beat_cnt and idle_cnt, go to BUSY.
  - Arbitration costs exactly 1 bubble cycle. The first transfer can occur on the cycle after the decision.
  - When fifo_prog_full=1, stay in IDLE regardless of requests.
- BUSY:
  - grant_vld=1, grant_id=gnt_q.
  - req_ready[gnt_q] = !fifo_wfull; every other bit of req_ready is 0.
  - xfer = req_valid[gnt_q] & req_ready[gnt_q].
  - fifo_wren = xfer (combinational). fifo_wdata = req_data of gnt_q, driven whenever in BUSY.
  - On xfer, beat_cnt++ and idle_cnt is cleared.
  - Burst end: on xfer with req_last[gnt_q]=1, or with beat_cnt==MAX_BURST-1. Then go to IDLE with rr_ptr = gnt_q+1 mod NREQ.
  - Stall by full: fifo_wfull=1 keeps state, beat_cnt and idle_cnt unchanged. A full FIFO never counts as idle.
  - Requester idle: req_valid[gnt_q]=0 with fifo_wfull=0 increments idle_cnt. When idle_cnt reaches TIMEOUT-1 on such a cycle, go to IDLE and advance rr_ptr (grant revoked).
  - fifo_prog_full does not interrupt a burst in progress.
- Simultaneous events:
  - last and MAX_BURST on the same beat give a single burst end.
  - Exiting BUSY, the next IDLE cycle may re-grant immediately. The requester just served has lowest priority on that re-grant.
- Outputs depend combinationally on fifo_wfull and req_valid. Nothing is registered between requester and FIFO, so a beat accepted in cycle t is written in cycle t.
- FIFO safety invariant: fifo_wren is never 1 while fifo_wfull is 1.
- Reset mid-burst: the next edge returns to IDLE with all counters cleared. Any beat not yet accepted is not written.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE, ST_BUSY);
  - the function computing IW from NREQ;
  - the packed-bus slice helper.
- One sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Fairness: NREQ=4, all four valid continuously with last every 2 beats → grant order 0,1,2,3,0. Each burst is 2 fifo_wren beats followed by 1 bubble cycle.
- Max burst: requester 2 valid with last never asserted, MAX_BURST=8 → exactly 8 writes, then IDLE. If requester 2 is alone it is re-granted after 1 bubble. With requester 3 also valid, 3 is granted next.
- Full stall: during a burst, fifo_wfull=1 for 5 cycles → req_ready=0 and fifo_wren=0 throughout, beat_cnt frozen, no timeout. The burst resumes when full deasserts, and no data is lost or duplicated (compare against a scoreboard).
- Prog_full gating: fifo_prog_full=1 in IDLE with requests pending → no grant. Raising prog_full mid-burst → the burst still completes through last.
- Timeout: granted requester 1 drops valid for 15 cycles, TIMEOUT=15 → return to IDLE on the 15th idle cycle and grant passes to requester 2.
- Reset mid-burst: assert rst for 1 cycle at beat 3 → all outputs 0 on the next cycle and rr_ptr=0, so requester 0 wins the next arbitration.
